mac_rx_framer: RTL and testbench
================================

Name: mac_rx_framer

Overview:
Receive-side framer that consumes the MAC byte stream (valid/byte/last, last byte = FCS) produced by the TX stage or the loopback path. Stores the payload in a single internal frame buffer and checks the trailing FCS byte against a fixed value. Checks the payload length against min/max bounds, reports per-frame status, and drains good frames downstream over a valid/ready byte interface. Frames that arrive while a frame is draining are dropped and counted.

Parameters:
MAX_LEN, 256, payload buffer depth in bytes (maximum storable payload)
MIN_LEN, 1, minimum legal payload length in bytes
FCS_VALUE, 8'h00, required value of the trailing FCS byte

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
rx_valid  input  1  incoming byte valid (no backpressure; must be accepted or dropped)
rx_byte  input  8  incoming byte
rx_last  input  1  qualifies FCS byte (final byte of frame)
out_valid  output  1  drained payload byte valid
out_ready  input  1  downstream accepts byte
out_byte  output  8  drained payload byte
out_last  output  1  final payload byte of drained frame
frame_done  output  1  one-cycle pulse: frame status valid
frame_ok  output  1  frame passed all checks (valid with frame_done)
frame_len  output  $clog2(MAX_LEN+1)  stored payload length (valid with frame_done)
err_fcs  output  1  FCS mismatch (valid with frame_done)
err_len  output  1  runt (<MIN_LEN) or oversize (>MAX_LEN) (valid with frame_done)
drop_cnt  output  16  frames dropped while busy, saturating

Behaviour:
- Reset (async, rst=1): state=IDLE, wr_ptr=0, rd_ptr=0, oversize=0, in_drop=0. All outputs 0 (out_valid, out_last, frame_done, frame_ok, err_*, frame_len, drop_cnt, out_byte). Buffer contents are not reset. Reset mid-frame or mid-drain abandons the frame; no status is reported.
- States: IDLE, RECV, DRAIN, DISCARD.
- IDLE:
  - rx_valid & !rx_last: write buf[0], wr_ptr=1, go RECV.
  - rx_valid & rx_last: zero-length frame; evaluate status as below.
- RECV:
  - rx_valid & !rx_last: if wr_ptr<MAX_LEN, write buf[wr_ptr] and wr_ptr++; else set oversize and do not write.
  - rx_valid & rx_last: rx_byte is the FCS byte; it is never stored.
- Status evaluation (on the edge sampling rx_last):
  - err_fcs = (rx_byte != FCS_VALUE).
  - err_len = oversize | (wr_ptr < MIN_LEN).
  - frame_ok = !err_fcs & !err_len.
  - frame_len = wr_ptr, saturated at MAX_LEN.
  - All registered; frame_done pulses high exactly the next cycle, and the status outputs hold until the next frame_done.
  - frame_ok=1: go DRAIN with rd_ptr=0. Otherwise go IDLE (frame discarded).
  - wr_ptr and oversize are cleared.
- rx_valid=0 cycles inside RECV: hold state; there is no timeout.
- DRAIN:
  - out_valid=1 starting the cycle frame_done pulses.
  - out_byte = buf[rd_ptr]; out_last = (rd_ptr == frame_len-1).
  - On out_valid & out_ready: rd_ptr++.
  - On accepting the out_last byte: go IDLE, or DISCARD if in_drop=1.
  - out_byte/out_last are stable while out_valid & !out_ready.
- Drop during DRAIN:
  - Any rx_valid sets in_drop.
  - rx_valid & rx_last: drop_cnt++ (saturating at 16'hFFFF) and clear in_drop.
  - A dropped frame is never written to the buffer and never produces frame_done.
- DISCARD: ignore bytes until rx_valid & rx_last, then drop_cnt++, clear in_drop, go IDLE.
- Simultaneous events:
  - Drain of the final byte and rx_last in the same cycle: the incoming frame counts as dropped, and the next state is IDLE.
  - Drain completing in the same cycle a new frame's first byte arrives: that byte sets in_drop, and the next state is DISCARD. No frame is ever partially captured.
- Back-to-back frames: a first byte arriving in the cycle after rx_last (status cycle) is accepted from IDLE if the previous frame failed. It is dropped if the previous frame entered DRAIN.
- Latency: last payload byte in to first out_valid = 2 cycles (FCS cycle + 1). Throughput: 1 byte/cycle in and out.

Test Plan:
- Payload 11 22 33 44, FCS 00, out_ready=1 -> frame_done 1 cycle after FCS, frame_ok=1, frame_len=4, err_*=0; out stream 11 22 33 44, out_last with 44; return to IDLE.
- Payload AA BB, FCS 5A -> frame_done, frame_ok=0, err_fcs=1, frame_len=2; out_valid never asserts.
- Frame of MAX_LEN payload bytes (00..FF), FCS 00 -> frame_ok=1, frame_len=256, all 256 bytes drained in order. Same with 257 bytes -> err_len=1, frame_len=256, no drain.
- FCS-only frame (rx_valid & rx_last in IDLE, byte 00) -> err_len=1 (runt), frame_len=0, err_fcs=0.
- Good 4-byte frame with out_ready=0 for 20 cycles, while 3-byte frame plus FCS arrives -> drop_cnt=1, no second frame_done; original 4 bytes then drain intact when out_ready=1.
- Assert rst asynchronously after 2 of 4 bytes drained -> out_valid=0 immediately, drop_cnt=0; next good frame 01 02, FCS 00 -> frame_ok=1, frame_len=2, drains 01 02.

Source files
------------

// File: rtl/mac_rx_framer.sv
// Receive framer: buffers one frame's payload, checks the trailing FCS byte and the length,
// reports per-frame status and drains good frames over a valid/ready byte stream.
module mac_rx_framer #(
    parameter int unsigned MAX_LEN   = 256,
    parameter int unsigned MIN_LEN   = 1,
    parameter logic [7:0]  FCS_VALUE = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_byte,
    input  logic                         rx_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_byte,
    output logic                         out_last,
    output logic                         frame_done,
    output logic                         frame_ok,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    output logic                         err_fcs,
    output logic                         err_len,
    output logic [15:0]                  drop_cnt
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECV    = 2'd1,
        S_DRAIN   = 2'd2,
        S_DISCARD = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic          oversize_q, oversize_d;
    logic          in_drop_q, in_drop_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [7:0]    out_byte_q, out_byte_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_ok_q, frame_ok_d;
    logic [LW-1:0] frame_len_q, frame_len_d;
    logic          err_fcs_q, err_fcs_d;
    logic          err_len_q, err_len_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic [7:0]    mem [MAX_LEN];
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic          rx_end;
    logic          count_drop;
    logic          status_fcs;
    logic          status_len;
    logic          status_ok;

    // Next-state and output computation
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        oversize_d   = oversize_q;
        in_drop_d    = in_drop_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_byte_d   = out_byte_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        frame_len_d  = frame_len_q;
        err_fcs_d    = err_fcs_q;
        err_len_d    = err_len_q;
        drop_cnt_d   = drop_cnt_q;
        buf_we       = 1'b0;
        buf_waddr    = wr_ptr_q[AW-1:0];
        count_drop   = 1'b0;
        rx_end       = rx_valid & rx_last;
        status_fcs   = (rx_byte != FCS_VALUE);
        status_len   = oversize_q | (wr_ptr_q < LW'(MIN_LEN));
        status_ok    = !status_fcs && !status_len;

        case (state_q)
            S_IDLE: begin
                if (rx_valid && !rx_last) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    wr_ptr_d  = LW'(1);
                    state_d   = S_RECV;
                end
            end
            S_RECV: begin
                if (rx_valid && !rx_last) begin
                    if (wr_ptr_q < LW'(MAX_LEN)) begin
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + LW'(1);
                    end else begin
                        oversize_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Any traffic while draining belongs to a frame that will be dropped
                if (rx_valid) begin
                    in_drop_d  = !rx_last;
                    count_drop = rx_last;
                end
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = in_drop_d ? S_DISCARD : S_IDLE;
                    end else begin
                        rd_ptr_d   = rd_ptr_q + LW'(1);
                        out_byte_d = mem[rd_ptr_d[AW-1:0]];
                        out_last_d = (rd_ptr_d == frame_len_q - LW'(1));
                    end
                end
            end
            S_DISCARD: begin
                if (rx_end) begin
                    count_drop = 1'b1;
                    in_drop_d  = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // FCS byte of a captured frame: latch status and decide whether to drain
        if (rx_end && (state_q == S_IDLE || state_q == S_RECV)) begin
            frame_done_d = 1'b1;
            err_fcs_d    = status_fcs;
            err_len_d    = status_len;
            frame_ok_d   = status_ok;
            frame_len_d  = wr_ptr_q;
            wr_ptr_d     = '0;
            oversize_d   = 1'b0;
            if (status_ok && (wr_ptr_q != '0)) begin
                state_d     = S_DRAIN;
                rd_ptr_d    = '0;
                out_valid_d = 1'b1;
                out_byte_d  = mem['0];
                out_last_d  = (wr_ptr_q == LW'(1));
            end else begin
                state_d = S_IDLE;
            end
        end

        if (count_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Payload buffer, intentionally not reset
    always_ff @(posedge clk) begin
        if (buf_we) begin
            mem[buf_waddr] <= rx_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            oversize_q   <= 1'b0;
            in_drop_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_byte_q   <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_len_q  <= '0;
            err_fcs_q    <= 1'b0;
            err_len_q    <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            oversize_q   <= oversize_d;
            in_drop_q    <= in_drop_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_byte_q   <= out_byte_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            frame_len_q  <= frame_len_d;
            err_fcs_q    <= err_fcs_d;
            err_len_q    <= err_len_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_byte   = out_byte_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign frame_len  = frame_len_q;
    assign err_fcs    = err_fcs_q;
    assign err_len    = err_len_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_mac_rx_framer.sv
// Scoreboard bench for mac_rx_framer: a frame-level model predicts status, drained bytes
// and drops; a negedge monitor compares whatever the DUT presents against the queues.
module tb_mac_rx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_last = 1'b0;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic       frame_done;
    logic       frame_ok;
    logic [8:0] frame_len;
    logic       err_fcs;
    logic       err_len;
    logic [15:0] drop_cnt;

    mac_rx_framer dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_last(rx_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
        .frame_done(frame_done), .frame_ok(frame_ok), .frame_len(frame_len),
        .err_fcs(err_fcs), .err_len(err_len), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_n;
        int ok;
        int len;
        int efcs;
        int elen;
    } stat_t;

    stat_t      stat_q[$];
    logic [8:0] byte_q[$];
    stat_t      mon_s;
    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int drain_lo = 0;
    int drain_hi = -1;
    int exp_drop = 0;
    int ready_mode = 1;
    logic [7:0] pl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    // Drives one frame, then predicts its fate: dropped if its first byte lands while
    // the previously accepted good frame is draining, otherwise a status (and bytes if good)
    task automatic send_frame(input logic [7:0] p[$], input logic [7:0] fcs, input int gap_pct);
        int first_edge;
        int t;
        int n;
        stat_t s;
        logic [8:0] e;
        n = p.size();
        first_edge = -1;
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) tick();
            rx_valid = 1'b1; rx_byte = p[i]; rx_last = 1'b0;
            tick();
            if (i == 0) first_edge = edge_n;
            rx_valid = 1'b0; rx_byte = 8'($urandom);
        end
        while (int'($urandom_range(99)) < gap_pct) tick();
        rx_valid = 1'b1; rx_byte = fcs; rx_last = 1'b1;
        tick();
        t = edge_n;
        rx_valid = 1'b0; rx_last = 1'b0; rx_byte = 8'($urandom);
        if (n == 0) first_edge = t;
        if (first_edge >= drain_lo && first_edge <= drain_hi) begin
            if (exp_drop < 65535) exp_drop++;
        end else begin
            s.edge_n = t;
            s.efcs   = (fcs != 8'h00) ? 1 : 0;
            s.elen   = (n < 1 || n > 256) ? 1 : 0;
            s.ok     = (s.efcs == 0 && s.elen == 0) ? 1 : 0;
            s.len    = (n > 256) ? 256 : n;
            stat_q.push_back(s);
            if (s.ok == 1) begin
                for (int i = 0; i < n; i++) begin
                    e = {(i == n - 1), p[i]};
                    byte_q.push_back(e);
                end
                drain_lo = t + 1;
                drain_hi = t + n;
            end
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((byte_q.size() != 0 || stat_q.size() != 0) && k < 5000) begin
            tick();
            k++;
        end
        check("drain_timeout", byte_q.size() + stat_q.size(), 0);
        tick();
        tick();
    endtask

    // out_ready driver: fixed low, fixed high or random per cycle
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: status pulses and presented bytes are checked against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (stat_q.size() == 0) begin
                check("spurious_frame_done", frame_done, 0);
            end else if (frame_done) begin
                mon_s = stat_q.pop_front();
                check("done_edge", edge_n, mon_s.edge_n);
                check("frame_ok", frame_ok, mon_s.ok);
                check("frame_len", frame_len, mon_s.len);
                check("err_fcs", err_fcs, mon_s.efcs);
                check("err_len", err_len, mon_s.elen);
                if (mon_s.ok == 1) check("out_valid_at_done", out_valid, 1);
            end
            if (byte_q.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else if (out_valid) begin
                check("out_byte", out_byte, byte_q[0][7:0]);
                check("out_last", out_last, byte_q[0][8]);
                if (out_ready) void'(byte_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fcs;
        int n;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_byte", out_byte, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_err_fcs", err_fcs, 0);
        check("rst_err_len", err_len, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        pl = {8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(pl, 8'h00, 0);
        wait_drain();
        pl = {8'hAA, 8'hBB};
        send_frame(pl, 8'h5A, 0);
        wait_drain();
        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'(i));
        send_frame(pl, 8'h00, 0);
        wait_drain();
        pl.push_back(8'h77);
        send_frame(pl, 8'h00, 0);
        wait_drain();
        pl.delete();
        send_frame(pl, 8'h00, 0);
        wait_drain();

        // Hold the output while a second frame arrives: it must be dropped
        ready_mode = 0;
        pl = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
        send_frame(pl, 8'h00, 0);
        drain_hi = 32'h7FFF_FFFF;
        pl = {8'hD1, 8'hD2, 8'hD3};
        send_frame(pl, 8'h00, 0);
        repeat (15) tick();
        check("drop_cnt_hold", drop_cnt, exp_drop);
        ready_mode = 1;
        wait_drain();
        drain_hi = -1;

        // Asynchronous reset after two of four bytes have drained
        pl = {8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(pl, 8'h00, 0);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_drop_cnt", drop_cnt, 0);
        byte_q.delete();
        stat_q.delete();
        exp_drop = 0;
        drain_hi = -1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        pl = {8'h01, 8'h02};
        send_frame(pl, 8'h00, 0);
        wait_drain();

        // Random frames, random backpressure, one frame at a time
        ready_mode = 2;
        repeat (25) begin
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            fcs = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame(pl, fcs, 20);
            wait_drain();
        end

        // Random back-to-back frames with out_ready high: exercises drops and collisions
        ready_mode = 1;
        tick();
        repeat (60) begin
            n = int'($urandom_range(0, 6));
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            fcs = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame(pl, fcs, 15);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_drain();
        check("drop_cnt_final", drop_cnt, exp_drop);
        check("scoreboard_empty", byte_q.size() + stat_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
